// File: rtl/cluster_req_sched.sv
// Credit-limited N:1 request scheduler with a registered output stage and tag-based response router.
// Define CLUSTER_REQ_SCHED_RR_EN for round-robin arbitration; default is fixed priority (lowest index).
module cluster_req_sched #(
  parameter int NUM_REQ    = 4,
  parameter int PAYLOAD_W  = 600,
  parameter int SRC_W      = 8,
  parameter int RSP_W      = 550,
  parameter int MAX_OUTSTD = 8,
  localparam int IDX_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_OUTSTD + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i,
  input  logic [NUM_REQ*SRC_W-1:0]   req_source_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [PAYLOAD_W-1:0]       out_payload_o,
  output logic [IDX_W+SRC_W-1:0]     out_source_o,
  input  logic                       rsp_valid_i,
  output logic                       rsp_ready_o,
  input  logic [IDX_W+SRC_W-1:0]     rsp_source_i,
  input  logic [RSP_W-1:0]           rsp_payload_i,
  output logic [NUM_REQ-1:0]         rsp_vec_valid_o,
  input  logic [NUM_REQ-1:0]         rsp_vec_ready_i,
  output logic [NUM_REQ*RSP_W-1:0]   rsp_vec_payload_o,
  output logic [NUM_REQ*SRC_W-1:0]   rsp_vec_source_o,
  output logic [NUM_REQ-1:0]         credit_full_o,
  output logic                       err_o
);

  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                          out_valid_q, out_valid_d;
  logic [PAYLOAD_W-1:0]          out_payload_q, out_payload_d;
  logic [IDX_W+SRC_W-1:0]        out_source_q, out_source_d;
  logic                          err_q, err_d;

  logic [NUM_REQ-1:0] credit_full, eligible, cnt_inc, cnt_dec;
  logic               grant_vld, load_en, req_hs, rsp_hs, tag_ok;
  logic [IDX_W-1:0]   grant_idx, rsp_tag;

  assign load_en = ~out_valid_q | out_ready_i;
  assign req_hs  = grant_vld & load_en & rst_n;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign credit_full[gi] = (cnt_q[gi] == CNT_W'(MAX_OUTSTD));
    assign eligible[gi]    = req_valid_i[gi] & ~credit_full[gi];
    assign cnt_inc[gi]     = req_hs & (grant_idx == IDX_W'(gi));
    assign cnt_dec[gi]     = rsp_hs & (rsp_tag == IDX_W'(gi));
    assign rsp_vec_valid_o[gi] = rsp_valid_i & (rsp_tag == IDX_W'(gi));
    assign rsp_vec_payload_o[gi*RSP_W +: RSP_W] = rsp_payload_i;
    assign rsp_vec_source_o[gi*SRC_W +: SRC_W]  = rsp_source_i[SRC_W-1:0];
  end

`ifdef CLUSTER_REQ_SCHED_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Search upward from the pointer with wrap; first eligible requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && eligible[IDX_W'((int'(ptr_q) + k) % NUM_REQ)]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (req_hs) ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Scan downward so the lowest eligible index is the last assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    req_ready_o = '0;
    if (req_hs) req_ready_o[grant_idx] = 1'b1;
  end

  // Unknown tags are swallowed so a bad response can never stall the return path.
  assign rsp_tag = rsp_source_i[IDX_W+SRC_W-1 -: IDX_W];
  assign tag_ok  = ({1'b0, rsp_tag} < (IDX_W+1)'(NUM_REQ));

  always_comb begin
    rsp_ready_o = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rsp_tag == IDX_W'(k)) rsp_ready_o = rsp_vec_ready_i[k];
    end
  end

  assign rsp_hs = rsp_valid_i & rsp_ready_o & tag_ok;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (rsp_valid_i && !tag_ok) err_d = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cnt_dec[k] && cnt_q[k] == '0) err_d = 1'b1;
      if (cnt_inc[k] && !cnt_dec[k])
        cnt_d[k] = cnt_q[k] + 1'b1;
      else if (cnt_dec[k] && !cnt_inc[k] && cnt_q[k] != '0)
        cnt_d[k] = cnt_q[k] - 1'b1;
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_payload_d = out_payload_q;
    out_source_d  = out_source_q;
    if (req_hs) begin
      out_valid_d   = 1'b1;
      out_payload_d = req_payload_i[grant_idx*PAYLOAD_W +: PAYLOAD_W];
      out_source_d  = {grant_idx, req_source_i[grant_idx*SRC_W +: SRC_W]};
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_payload_q <= '0;
      out_source_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_payload_q <= out_payload_d;
      out_source_q  <= out_source_d;
      err_q         <= err_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_payload_o = out_payload_q;
  assign out_source_o  = out_source_q;
  assign credit_full_o = credit_full;
  assign err_o         = err_q;

endmodule

// File: tb/tb_cluster_req_sched.sv
// Scoreboard bench for cluster_req_sched: accepted requests are queued and compared as they leave.
module tb_cluster_req_sched;
  localparam int N  = 4;
  localparam int PW = 600;
  localparam int SW = 8;
  localparam int RW = 550;
  localparam int IW = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid_i;
  logic [N-1:0]       req_ready_o;
  logic [N*PW-1:0]    req_payload_i;
  logic [N*SW-1:0]    req_source_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [PW-1:0]      out_payload_o;
  logic [IW+SW-1:0]   out_source_o;
  logic               rsp_valid_i;
  logic               rsp_ready_o;
  logic [IW+SW-1:0]   rsp_source_i;
  logic [RW-1:0]      rsp_payload_i;
  logic [N-1:0]       rsp_vec_valid_o;
  logic [N-1:0]       rsp_vec_ready_i;
  logic [N*RW-1:0]    rsp_vec_payload_o;
  logic [N*SW-1:0]    rsp_vec_source_o;
  logic [N-1:0]       credit_full_o;
  logic               err_o;

  cluster_req_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_payload_i(req_payload_i), .req_source_i(req_source_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_payload_o(out_payload_o), .out_source_o(out_source_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .rsp_source_i(rsp_source_i), .rsp_payload_i(rsp_payload_i),
    .rsp_vec_valid_o(rsp_vec_valid_o), .rsp_vec_ready_i(rsp_vec_ready_i),
    .rsp_vec_payload_o(rsp_vec_payload_o), .rsp_vec_source_o(rsp_vec_source_o),
    .credit_full_o(credit_full_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef logic [IW+SW+PW-1:0] sb_t;
  sb_t           sb_q[$];
  logic [PW-1:0] cur_pl  [N];
  logic [SW-1:0] cur_src [N];
  logic [N-1:0]  hs_mask;
  int            n_pass = 0;
  int            n_total = 0;

  function automatic logic [PW-1:0] make_pl(input logic [31:0] seed);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < 18; k++) p[k*32 +: 32] = seed ^ (32'h9E3779B9 * 32'(k + 1));
    p[PW-1 -: 24] = seed[23:0];
    return p;
  endfunction

  task automatic new_req(input int i);
    cur_src[i] = SW'($urandom);
    cur_pl[i]  = make_pl($urandom);
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_payload_i[i*PW +: PW] = cur_pl[i];
      req_source_i[i*SW +: SW]  = cur_src[i];
    end
  endtask

  // One clock: compare any leaving request, queue any accepted one, then move to the next negedge.
  task automatic tick();
    sb_t exp_e;
    #1;
    if (out_valid_o && out_ready_i) begin
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_out: got src=%h with no request queued", out_source_o);
      end else begin
        exp_e = sb_q.pop_front();
        if ({out_source_o, out_payload_o} !== exp_e)
          $display("FAIL sb_out: got src=%h pl_lo=%h, expected src=%h pl_lo=%h",
                   out_source_o, out_payload_o[63:0], exp_e[PW+IW+SW-1:PW], exp_e[63:0]);
        else n_pass++;
      end
    end
    hs_mask = req_valid_i & req_ready_o;
    for (int i = 0; i < N; i++) begin
      if (hs_mask[i]) begin
        sb_q.push_back({IW'(i), cur_src[i], cur_pl[i]});
        $display("accept req=%0d src=%h", i, cur_src[i]);
        new_req(i);
      end
    end
    @(negedge clk);
    pack();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid_i = '0; out_ready_i = 1'b1;
    rsp_valid_i = 1'b0; rsp_source_i = '0; rsp_payload_i = '0; rsp_vec_ready_i = '0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stimulus only: offers n cycles from requester i alone and returns how many were accepted.
  task automatic fill(input int i, input int n, output int got);
    got = 0;
    req_valid_i = N'(1) << i;
    out_ready_i = 1'b1;
    repeat (n) begin
      tick();
      got += int'(hs_mask[i]);
    end
    req_valid_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid_i = '1; out_ready_i = 1'b1;
    rsp_valid_i = 1'b0; rsp_source_i = '0; rsp_payload_i = '0; rsp_vec_ready_i = '0;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (req_ready_o !== 4'b0000) $display("FAIL rst_ready: got %b expected 0000", req_ready_o); else n_pass++;
    n_total++; if (credit_full_o !== 4'b0000) $display("FAIL rst_credit: got %b expected 0000", credit_full_o); else n_pass++;
    n_total++; if (out_valid_o !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b expected 0", err_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++; if (req_ready_o !== 4'b0001) $display("FAIL first_accept: got %b expected 0001", req_ready_o); else n_pass++;
    tick();
    req_valid_i = '0;
    repeat (2) tick();
  endtask

  task automatic test_arbitration();
    logic [N-1:0] exp_g;
    do_reset();
    req_valid_i = '1; out_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
`ifdef CLUSTER_REQ_SCHED_RR_EN
      exp_g = N'(1) << (c % N);
`else
      exp_g = N'(1);
`endif
      tick();
      n_total++;
      if (hs_mask !== exp_g) $display("FAIL arb_grant c%0d: got %b expected %b", c, hs_mask, exp_g);
      else n_pass++;
    end
    req_valid_i = '0;
    repeat (2) tick();
  endtask

  task automatic test_credit();
    int got;
    do_reset();
    fill(2, 8, got);
    n_total++; if (got != 8) $display("FAIL credit_fill: got %0d accepts expected 8", got); else n_pass++;
    req_valid_i = 4'b0100;
    #1;
    n_total++; if (credit_full_o !== 4'b0100) $display("FAIL credit_full: got %b expected 0100", credit_full_o); else n_pass++;
    n_total++; if (req_ready_o[2] !== 1'b0) $display("FAIL credit_block: got %b expected 0", req_ready_o[2]); else n_pass++;
    tick();
    rsp_valid_i = 1'b1; rsp_source_i = {2'd2, 8'h55}; rsp_vec_ready_i = 4'b0100;
    #1;
    n_total++; if (req_ready_o[2] !== 1'b0) $display("FAIL credit_same_cycle: got %b expected 0", req_ready_o[2]); else n_pass++;
    tick();
    rsp_valid_i = 1'b0;
    #1;
    n_total++; if (req_ready_o[2] !== 1'b1) $display("FAIL credit_release: got %b expected 1", req_ready_o[2]); else n_pass++;
    n_total++; if (credit_full_o !== 4'b0000) $display("FAIL credit_clear: got %b expected 0000", credit_full_o); else n_pass++;
    tick();
    req_valid_i = '0;
    repeat (2) tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid_i = 4'b0001; out_ready_i = 1'b0;
    #1;
    n_total++; if (req_ready_o !== 4'b0001) $display("FAIL bp_first: got %b expected 0001", req_ready_o); else n_pass++;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_total++; if (out_valid_o !== 1'b1) $display("FAIL bp_valid c%0d: got %b expected 1", c, out_valid_o); else n_pass++;
      n_total++;
      if (sb_q.size() == 0) $display("FAIL bp_queue c%0d: got empty queue expected 1 entry", c);
      else if (out_payload_o !== sb_q[0][PW-1:0]) $display("FAIL bp_hold c%0d: got %h expected %h", c, out_payload_o[63:0], sb_q[0][63:0]);
      else n_pass++;
      n_total++; if (req_ready_o !== 4'b0000) $display("FAIL bp_ready c%0d: got %b expected 0000", c, req_ready_o); else n_pass++;
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    n_total++; if (req_ready_o !== 4'b0001) $display("FAIL bp_release: got %b expected 0001", req_ready_o); else n_pass++;
    tick();
    req_valid_i = '0;
    repeat (2) tick();
  endtask

  task automatic test_rsp_route();
    int got;
    logic [RW-1:0] pl;
    do_reset();
    fill(1, 8, got);
    pl = '0;
    pl[63:0] = {$urandom, $urandom};
    pl[RW-1 -: 32] = $urandom;
    rsp_valid_i = 1'b1; rsp_source_i = {2'd1, 8'h3C}; rsp_payload_i = pl; rsp_vec_ready_i = 4'b0000;
    #1;
    n_total++; if (rsp_ready_o !== 1'b0) $display("FAIL rsp_stall: got %b expected 0", rsp_ready_o); else n_pass++;
    tick();
    rsp_vec_ready_i = 4'b0010;
    #1;
    n_total++; if (rsp_vec_valid_o !== 4'b0010) $display("FAIL rsp_valid_vec: got %b expected 0010", rsp_vec_valid_o); else n_pass++;
    n_total++; if (rsp_vec_source_o[1*SW +: SW] !== 8'h3C) $display("FAIL rsp_src: got %h expected 3c", rsp_vec_source_o[1*SW +: SW]); else n_pass++;
    n_total++; if (rsp_ready_o !== 1'b1) $display("FAIL rsp_ready: got %b expected 1", rsp_ready_o); else n_pass++;
    n_total++; if (rsp_vec_payload_o[3*RW +: RW] !== pl) $display("FAIL rsp_bcast: got %h expected %h", rsp_vec_payload_o[3*RW +: 64], pl[63:0]); else n_pass++;
    n_total++; if (credit_full_o !== 4'b0010) $display("FAIL rsp_pre_full: got %b expected 0010", credit_full_o); else n_pass++;
    tick();
    rsp_valid_i = 1'b0;
    #1;
    n_total++; if (credit_full_o !== 4'b0000) $display("FAIL rsp_decrement: got %b expected 0000", credit_full_o); else n_pass++;
    tick();
  endtask

  task automatic test_error_and_same_cycle();
    int got;
    do_reset();
    rsp_valid_i = 1'b1; rsp_source_i = {2'd1, 8'h00}; rsp_vec_ready_i = 4'b1111;
    tick();
    rsp_valid_i = 1'b0;
    #1;
    n_total++; if (err_o !== 1'b1) $display("FAIL err_set: got %b expected 1", err_o); else n_pass++;
    fill(1, 7, got);
    #1;
    n_total++; if (credit_full_o[1] !== 1'b0) $display("FAIL err_cnt_floor7: got %b expected 0", credit_full_o[1]); else n_pass++;
    fill(1, 1, got);
    #1;
    n_total++; if (credit_full_o[1] !== 1'b1) $display("FAIL err_cnt_floor8: got %b expected 1", credit_full_o[1]); else n_pass++;
    n_total++; if (err_o !== 1'b1) $display("FAIL err_sticky: got %b expected 1", err_o); else n_pass++;
    fill(3, 5, got);
    req_valid_i = 4'b1000;
    rsp_valid_i = 1'b1; rsp_source_i = {2'd3, 8'hA5}; rsp_vec_ready_i = 4'b1000;
    tick();
    n_total++; if (hs_mask !== 4'b1000) $display("FAIL same_cycle_accept: got %b expected 1000", hs_mask); else n_pass++;
    rsp_valid_i = 1'b0;
    fill(3, 2, got);
    #1;
    n_total++; if (credit_full_o[3] !== 1'b0) $display("FAIL same_cycle_cnt7: got %b expected 0", credit_full_o[3]); else n_pass++;
    fill(3, 1, got);
    #1;
    n_total++; if (credit_full_o !== 4'b1010) $display("FAIL same_cycle_cnt8: got %b expected 1010", credit_full_o); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int got;
    do_reset();
    rsp_valid_i = 1'b1; rsp_source_i = {2'd2, 8'h01}; rsp_vec_ready_i = 4'b1111;
    tick();
    rsp_valid_i = 1'b0;
    fill(0, 3, got);
    #2;
    n_total++; if (out_valid_o !== 1'b1 || err_o !== 1'b1) $display("FAIL mid_pre: got v=%b e=%b expected 1 1", out_valid_o, err_o); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (out_valid_o !== 1'b0) $display("FAIL mid_valid: got %b expected 0", out_valid_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL mid_err: got %b expected 0", err_o); else n_pass++;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    fill(0, 7, got);
    #1;
    n_total++; if (credit_full_o[0] !== 1'b0) $display("FAIL mid_cnt7: got %b expected 0", credit_full_o[0]); else n_pass++;
    fill(0, 1, got);
    #1;
    n_total++; if (credit_full_o[0] !== 1'b1) $display("FAIL mid_cnt8: got %b expected 1", credit_full_o[0]); else n_pass++;
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) new_req(i);
    pack();
    test_reset();
    test_arbitration();
    test_credit();
    test_backpressure();
    test_rsp_route();
    test_error_and_same_cycle();
    test_reset_mid();
    n_total++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cluster_req_sched.md
CLUSTER_REQ_SCHED -- requirements
Module: cluster_req_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (SMs); NUM_REQ >= 2.
REQ-002 SHALL have parameter PAYLOAD_W, default 600: request payload width (opcode/size/address/mask/data/param).
REQ-003 SHALL have parameter SRC_W, default 8: per-requester source tag width.
REQ-004 SHALL have parameter RSP_W, default 550: response payload width.
REQ-005 SHALL have parameter MAX_OUTSTD, default 8: maximum in-flight requests per requester; IDX_W = clog2(NUM_REQ), CNT_W = clog2(MAX_OUTSTD+1).
REQ-006 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port req_valid_i, input, NUM_REQ: per-requester request valid.
REQ-009 SHALL have port req_ready_o, output, NUM_REQ: per-requester request accept.
REQ-010 SHALL have ports req_payload_i, input, NUM_REQ*PAYLOAD_W, and req_source_i, input, NUM_REQ*SRC_W: packed per-requester fields, requester i at slice i.
REQ-011 SHALL have ports out_valid_o, output, 1; out_ready_i, input, 1; out_payload_o, output, PAYLOAD_W; out_source_o, output, IDX_W+SRC_W: merged downstream request.
REQ-012 SHALL have ports rsp_valid_i, input, 1; rsp_ready_o, output, 1; rsp_source_i, input, IDX_W+SRC_W; rsp_payload_i, input, RSP_W: downstream response.
REQ-013 SHALL have ports rsp_vec_valid_o, output, NUM_REQ; rsp_vec_ready_i, input, NUM_REQ; rsp_vec_payload_o, output, NUM_REQ*RSP_W; rsp_vec_source_o, output, NUM_REQ*SRC_W: routed responses.
REQ-014 SHALL have ports credit_full_o, output, NUM_REQ (counter i == MAX_OUTSTD) and err_o, output, 1 (sticky protocol error).

Function
REQ-015 SHALL hold one registered output stage; load_en = ~out_valid_o | out_ready_i (full throughput, one request per cycle).
REQ-016 SHALL compute eligible[i] = req_valid_i[i] & ~credit_full_o[i]; grant exactly one eligible requester per cycle via the arbiter (REQ-033).
REQ-017 SHALL assert req_ready_o[g] only for granted g and only when load_en; all other bits 0; req_ready_o SHALL NOT depend combinationally on req_ready of other ports beyond grant.
REQ-018 SHALL, on handshake with g, register out_payload_o = payload g, out_source_o = {g, req_source_i slice g}, out_valid_o = 1 next cycle.
REQ-019 SHALL clear out_valid_o when out_ready_i & out_valid_o and no new handshake; output fields hold while out_valid_o & ~out_ready_i.
REQ-020 SHALL keep per-requester counter cnt[i] (CNT_W): +1 on request handshake of i, -1 on response handshake with tag i; both same cycle -> unchanged.
REQ-021 SHALL, at cnt[i] == MAX_OUTSTD, deassert eligibility of i until a response for i is accepted; counter never exceeds MAX_OUTSTD.
REQ-022 SHALL route responses combinationally: tag = rsp_source_i[IDX_W+SRC_W-1 -: IDX_W]; rsp_vec_valid_o[i] = rsp_valid_i & (tag == i); rsp_ready_o = rsp_vec_ready_i[tag].
REQ-023 SHALL broadcast rsp_payload_i and rsp_source_i[SRC_W-1:0] to every rsp_vec slice.
REQ-024 SHALL, for tag >= NUM_REQ, drive rsp_ready_o = 1, assert no rsp_vec_valid_o, and set err_o.
REQ-025 SHALL, on response handshake for i with cnt[i] == 0, hold cnt[i] at 0 and set err_o.
REQ-026 SHALL keep err_o set until reset.
REQ-027 SHALL NOT deadlock: response path independent of request path state.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear out_valid_o, out_payload_o, out_source_o, all cnt, RR pointer, err_o.
REQ-029 SHALL drive req_ready_o = 0 and credit_full_o = 0 during reset.
REQ-030 SHALL, on reset mid-transfer, drop the buffered request; counters restart from 0.
REQ-031 SHALL accept requests from the first rising edge after rst_n deasserts.

Configuration
REQ-032 SHALL use macro CLUSTER_REQ_SCHED_RR_EN to select arbitration policy.
REQ-033 SHALL, with CLUSTER_REQ_SCHED_RR_EN defined, arbitrate round-robin: pointer p starts 0; search eligible from p upward with wrap; after handshake with g, p = (g+1) mod NUM_REQ; no handshake -> p unchanged. Without it, fixed priority, lowest index wins, no pointer state.

Verification
REQ-034 SHALL cover: all 4 valid, out_ready_i=1, RR_EN -> grants 0,1,2,3,0 on consecutive cycles; without RR_EN -> grant 0 every cycle.
REQ-035 SHALL cover: requester 2 issues 8 requests, no responses -> credit_full_o=4'b0100, req_ready_o[2]=0; one response tag 2 -> next cycle accepted again.
REQ-036 SHALL cover: out_ready_i=0 for 5 cycles after one accept -> out_valid_o=1, payload stable, req_ready_o=0; release -> drains, next accepted same cycle.
REQ-037 SHALL cover: rsp_source_i={2'd1,8'h3C}, rsp_vec_ready_i=4'b0010 -> rsp_vec_valid_o=4'b0010, rsp_vec_source_o slice 1 = 8'h3C, rsp_ready_o=1, cnt[1] decrements.
REQ-038 SHALL cover: response tag 1 with cnt[1]=0 -> err_o=1 stays set, cnt[1]=0; simultaneous req and rsp on requester 3 with cnt=5 -> cnt stays 5.
REQ-039 SHALL cover: rst_n pulsed low with out_valid_o=1 and cnt[0]=3 -> out_valid_o=0, cnt[0]=0, err_o=0 immediately.
